accum_sequencer: RTL and testbench

//  Controls the partial-sum accumulator register array. Accepts a stream of
//  VEC_WIDTH partial-sum vectors over K passes of R rows and does a lane-wise

---
 rtl/acc_pkg.sv | 23 ++
 rtl/acc_lane_add.sv | 35 +++
 rtl/accum_sequencer.sv | 162 ++++++++++++++++
 tb/tb_accum_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and default sizing for the partial-sum accumulator sequencer.
// Saturation limits below apply to the default lane width.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_VEC_WIDTH  = 384;
    localparam int DEF_LANE_WIDTH = 24;
    localparam int DEF_ARR_DEPTH  = 16;
    localparam int DEF_PASS_WIDTH = 8;
    localparam int NUM_LANES      = DEF_VEC_WIDTH / DEF_LANE_WIDTH;

    localparam logic [DEF_LANE_WIDTH-1:0] SAT_MAX =
        {1'b0, {(DEF_LANE_WIDTH-1){1'b1}}};
    localparam logic [DEF_LANE_WIDTH-1:0] SAT_MIN =
        {1'b1, {(DEF_LANE_WIDTH-1){1'b0}}};

endpackage

// File: rtl/acc_lane_add.sv
// One accumulator lane adder: wrapping two's complement add by default,
// clamping add (with clamp indication) when ACC_SAT_EN is defined.
module acc_lane_add
    import acc_pkg::*;
#(
    parameter int W = DEF_LANE_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
`ifdef ACC_SAT_EN
    ,
    output logic         sat
`endif
);

`ifdef ACC_SAT_EN
    logic [W:0] ext;

    assign ext = {a[W-1], a} + {b[W-1], b};

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        sat = ext[W] != ext[W-1];
        sum = ext[W-1:0];
        if (sat) begin
            if (ext[W]) sum = {1'b1, {(W-1){1'b0}}};
            else        sum = {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/accum_sequencer.sv
// Partial-sum accumulator sequencer: K-pass lane-wise RMW over R rows, then
// drains rows downstream. ACC_SAT_EN selects saturating adds and o_sat_flag.
module accum_sequencer
    import acc_pkg::*;
#(
    parameter int VEC_WIDTH  = DEF_VEC_WIDTH,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int ARR_DEPTH  = DEF_ARR_DEPTH,
    parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
    parameter int PASS_WIDTH = DEF_PASS_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_num_rows,
    input  logic [PASS_WIDTH-1:0] i_num_passes,
    input  logic                  i_psum_valid,
    output logic                  o_psum_ready,
    input  logic [VEC_WIDTH-1:0]  i_psum_data,
    output logic                  o_acc_we,
    output logic [ADDR_WIDTH-1:0] o_acc_addr_wr,
    output logic [VEC_WIDTH-1:0]  o_acc_data_wr,
    output logic [ADDR_WIDTH-1:0] o_acc_addr_rd,
    input  logic [VEC_WIDTH-1:0]  i_acc_data_rd,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [VEC_WIDTH-1:0]  o_out_data,
`ifdef ACC_SAT_EN
    output logic                  o_sat_flag,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
);

    localparam int LANES = VEC_WIDTH / LANE_WIDTH;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] drain;
    logic [PASS_WIDTH-1:0] pass;
    logic [ADDR_WIDTH:0]   rows_q;
    logic [PASS_WIDTH-1:0] passes_q;
    logic                  start_ok;
    logic                  accept;
    logic                  fire;
    logic                  row_last;
    logic                  pass_last;
    logic                  drain_last;
    logic [VEC_WIDTH-1:0]  sum_vec;

    assign start_ok = (i_num_rows != '0)
                   && (i_num_rows <= (ADDR_WIDTH+1)'(ARR_DEPTH))
                   && (i_num_passes != '0);
    assign accept     = (state == IDLE) && i_start && start_ok;
    assign fire       = (state == ACCUM) && i_psum_valid;
    assign row_last   = {1'b0, row} == rows_q - (ADDR_WIDTH+1)'(1);
    assign pass_last  = pass == passes_q - PASS_WIDTH'(1);
    assign drain_last = {1'b0, drain} == rows_q - (ADDR_WIDTH+1)'(1);

`ifdef ACC_SAT_EN
    logic [LANES-1:0] lane_sat;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        acc_lane_add #(.W(LANE_WIDTH)) u_add (
            .a   (i_acc_data_rd[g*LANE_WIDTH +: LANE_WIDTH]),
            .b   (i_psum_data[g*LANE_WIDTH +: LANE_WIDTH]),
            .sum (sum_vec[g*LANE_WIDTH +: LANE_WIDTH])
`ifdef ACC_SAT_EN
            ,
            .sat (lane_sat[g])
`endif
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = ACCUM;
            ACCUM: if (fire && row_last && pass_last) state_nx = DRAIN;
            DRAIN: if (i_out_ready && drain_last) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row      <= '0;
            pass     <= '0;
            drain    <= '0;
            rows_q   <= '0;
            passes_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    rows_q   <= i_num_rows;
                    passes_q <= i_num_passes;
                    row      <= '0;
                    pass     <= '0;
                    drain    <= '0;
                end
                ACCUM: if (fire) begin
                    if (row_last) begin
                        row  <= '0;
                        pass <= pass + PASS_WIDTH'(1);
                    end else begin
                        row  <= row + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: if (i_out_ready) drain <= drain + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef ACC_SAT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                             o_sat_flag <= 1'b0;
        else if (accept)                          o_sat_flag <= 1'b0;
        else if (fire && pass != '0 && |lane_sat) o_sat_flag <= 1'b1;
    end
`endif

    // Pass 0 overwrites so stale array contents never need a clear cycle.
    always_comb begin
        o_psum_ready  = 1'b0;
        o_acc_we      = 1'b0;
        o_acc_addr_wr = '0;
        o_acc_addr_rd = '0;
        o_acc_data_wr = '0;
        o_out_valid   = 1'b0;
        o_out_data    = '0;
        o_done        = 1'b0;
        unique case (state)
            ACCUM: begin
                o_psum_ready  = 1'b1;
                o_acc_we      = i_psum_valid;
                o_acc_addr_wr = row;
                o_acc_addr_rd = row;
                o_acc_data_wr = (pass == '0) ? i_psum_data : sum_vec;
            end
            DRAIN: begin
                o_acc_addr_rd = drain;
                o_out_valid   = 1'b1;
                o_out_data    = i_acc_data_rd;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_busy    = state != IDLE;
    assign o_cfg_err = (state == IDLE) && i_start && !start_ok;

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer: table of jobs plus random jobs,
// an integer-arithmetic expected-result model, and a mid-job reset sequence.
module tb_accum_sequencer;

    localparam int VW    = 384;
    localparam int LW    = 24;
    localparam int NL    = VW / LW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    num_rows;
    logic [7:0]    num_passes;
    logic          psum_valid;
    logic          psum_ready;
    logic [VW-1:0] psum_data;
    logic          acc_we;
    logic [3:0]    acc_addr_wr;
    logic [VW-1:0] acc_data_wr;
    logic [3:0]    acc_addr_rd;
    logic [VW-1:0] acc_data_rd;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          cfg_err;
`ifdef ACC_SAT_EN
    logic          sat_flag;
`endif

    always #5 clk = ~clk;

    accum_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_num_rows    (num_rows),
        .i_num_passes  (num_passes),
        .i_psum_valid  (psum_valid),
        .o_psum_ready  (psum_ready),
        .i_psum_data   (psum_data),
        .o_acc_we      (acc_we),
        .o_acc_addr_wr (acc_addr_wr),
        .o_acc_data_wr (acc_data_wr),
        .o_acc_addr_rd (acc_addr_rd),
        .i_acc_data_rd (acc_data_rd),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
`ifdef ACC_SAT_EN
        .o_sat_flag    (sat_flag),
`endif
        .o_busy        (busy),
        .o_done        (done),
        .o_cfg_err     (cfg_err)
    );

    // Accumulator array the DUT masters: registered write, combinational read.
    logic [VW-1:0] mem [DEPTH];
    always @(posedge clk) if (acc_we) mem[acc_addr_wr] <= acc_data_wr;
    assign acc_data_rd = mem[acc_addr_rd];

    int wr_cnt   = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (acc_we) wr_cnt++;
        if (done)   done_cnt++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk_i(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_v(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int rows;
        int passes;
        int mode;
        int stall;
        bit gaps;
        bit exp_err;
        int exp_lane0;
    } vec_t;

    logic [VW-1:0] beats[$];
    logic [VW-1:0] exp_rows[DEPTH];
    bit            exp_sat;

    function automatic int sx(logic [LW-1:0] x);
        return x[LW-1] ? int'(x) - (1 << LW) : int'(x);
    endfunction

    task automatic gen_beats(int r, int k, int mode);
        logic [VW-1:0] b;
        beats.delete();
        for (int i = 0; i < r * k; i++) begin
            b = '0;
            for (int l = 0; l < NL; l++) begin
                case (mode)
                    0:       b[l*LW +: LW] = 24'd1;
                    1:       b[l*LW +: LW] = 24'($urandom);
                    2:       if (l == 0) b[l*LW +: LW] = 24'(10 * (i + 1));
                    default: b[l*LW +: LW] = (i < r) ? 24'h7FFFF0 : 24'h000020;
                endcase
            end
            beats.push_back(b);
        end
    endtask

    // Row r of pass p is beat p*r_total+r; lanes summed as signed integers.
    task automatic build_expect(int r, int k);
        int acc;
        int v;
        exp_sat = 1'b0;
        for (int row = 0; row < r; row++) begin
            exp_rows[row] = '0;
            for (int l = 0; l < NL; l++) begin
                acc = 0;
                for (int p = 0; p < k; p++) begin
                    v = sx(beats[p*r + row][l*LW +: LW]);
                    if (p == 0) begin
                        acc = v;
                    end else begin
                        acc = acc + v;
`ifdef ACC_SAT_EN
                        if (acc > 8388607)  begin acc = 8388607;  exp_sat = 1'b1; end
                        if (acc < -8388608) begin acc = -8388608; exp_sat = 1'b1; end
`else
                        acc = sx(acc[LW-1:0]);
`endif
                    end
                end
                exp_rows[row][l*LW +: LW] = acc[LW-1:0];
            end
        end
    endtask

    task automatic start_job(int r, int k, bit exp_err);
        @(negedge clk);
        start      = 1'b1;
        num_rows   = 5'(r);
        num_passes = 8'(k);
        #1;
        chk_i("cfg_err", int'(cfg_err), int'(exp_err));
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_i("busy_after_start", int'(busy), exp_err ? 0 : 1);
        chk_i("cfg_err_pulse", int'(cfg_err), 0);
    endtask

    task automatic feed(int r, bit gaps, int limit);
        int idx = 0;
        int budget = 0;
        bit v;
        while (idx < limit && budget < 4000) begin
            @(negedge clk);
            v          = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            psum_valid = v;
            psum_data  = beats[idx];
            #1;
            chk_i("psum_ready", int'(psum_ready), 1);
            chk_i("acc_we", int'(acc_we), int'(v));
            if (v) begin
                chk_i("addr_wr", int'(acc_addr_wr), idx % r);
                chk_i("addr_rd_accum", int'(acc_addr_rd), idx % r);
                idx++;
            end
            budget++;
        end
        if (idx < limit) begin
            n_vec++;
            n_bad++;
            $display("FAIL feed_timeout: got %0d beats expected %0d", idx, limit);
        end
    endtask

    task automatic drain(int r, int stall, int lane0);
        bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int            got = 0;
        int            cyc = 0;
        bit            rdy;
        bit            stalled = 1'b0;
        logic [VW-1:0] pd = '0;
        int            pa = 0;
        while (got < r && cyc < 500) begin
            @(negedge clk);
            psum_valid = 1'b0;
            case (stall)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            #1;
            chk_i("out_valid", int'(out_valid), 1);
            chk_i("we_in_drain", int'(acc_we), 0);
            if (stalled) begin
                chk_v("stall_data", out_data, pd);
                chk_i("stall_addr", int'(acc_addr_rd), pa);
            end
            if (rdy) begin
                chk_v("drain_row", out_data, exp_rows[got]);
                chk_i("drain_addr", int'(acc_addr_rd), got);
                if (lane0 >= 0) chk_i("lane0", int'(out_data[LW-1:0]), lane0);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd      = out_data;
                pa      = int'(acc_addr_rd);
            end
            cyc++;
        end
        if (got < r) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d rows expected %0d", got, r);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk_i("done_pulse", int'(done), 1);
        chk_i("out_valid_done", int'(out_valid), 0);
        @(negedge clk);
        #1;
        chk_i("done_clear", int'(done), 0);
        chk_i("busy_idle", int'(busy), 0);
    endtask

    task automatic run_job(vec_t v);
        int w0;
        int d0;
        if (v.exp_err) begin
            w0 = wr_cnt;
            start_job(v.rows, v.passes, 1'b1);
            repeat (2) @(negedge clk);
            #1;
            chk_i("busy_err", int'(busy), 0);
            chk_i("we_err", wr_cnt - w0, 0);
            return;
        end
        gen_beats(v.rows, v.passes, v.mode);
        build_expect(v.rows, v.passes);
        w0 = wr_cnt;
        d0 = done_cnt;
        start_job(v.rows, v.passes, 1'b0);
        feed(v.rows, v.gaps, v.rows * v.passes);
        drain(v.rows, v.stall, v.exp_lane0);
        chk_i("write_count", wr_cnt - w0, v.rows * v.passes);
        chk_i("done_count", done_cnt - d0, 1);
`ifdef ACC_SAT_EN
        chk_i("sat_flag", int'(sat_flag), int'(exp_sat));
`endif
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        num_rows   = '0;
        num_passes = '0;
        psum_valid = 1'b0;
        psum_data  = '0;
        out_ready  = 1'b0;

`ifdef ACC_SAT_EN
        tbl[6] = '{2, 2, 3, 0, 1'b0, 1'b0, 32'h7FFFFF};
`else
        tbl[6] = '{2, 2, 3, 0, 1'b0, 1'b0, 32'h800010};
`endif
        tbl[0] = '{4,  3, 0, 0, 1'b0, 1'b0, 3};
        tbl[1] = '{1,  5, 2, 0, 1'b0, 1'b0, 150};
        tbl[2] = '{5,  2, 1, 1, 1'b0, 1'b0, -1};
        tbl[3] = '{0,  1, 0, 0, 1'b0, 1'b1, -1};
        tbl[4] = '{17, 1, 0, 0, 1'b0, 1'b1, -1};
        tbl[5] = '{3,  0, 0, 0, 1'b0, 1'b1, -1};
        tbl[7] = '{16, 2, 1, 2, 1'b1, 1'b0, -1};

        repeat (2) @(negedge clk);
        #1;
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_ready", int'(psum_ready), 0);
        chk_i("rst_we", int'(acc_we), 0);
        chk_i("rst_valid", int'(out_valid), 0);
        chk_i("rst_done", int'(done), 0);
        chk_v("rst_out_data", out_data, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        for (int i = 0; i < 4; i++) begin
            rv = '{int'($urandom_range(1, 16)), int'($urandom_range(1, 4)),
                   1, 2, 1'b1, 1'b0, -1};
            run_job(rv);
        end

        // Abort at pass 1, row 2 of an R=4, K=3 job.
        gen_beats(4, 3, 1);
        start_job(4, 3, 1'b0);
        feed(4, 1'b0, 6);
        @(negedge clk);
        psum_valid = 1'b1;
        psum_data  = beats[6];
        rst_n      = 1'b0;
        #1;
        chk_i("abort_busy", int'(busy), 0);
        chk_i("abort_ready", int'(psum_ready), 0);
        chk_i("abort_we", int'(acc_we), 0);
        chk_i("abort_valid", int'(out_valid), 0);
        chk_i("abort_done", int'(done), 0);
        chk_v("abort_data_wr", acc_data_wr, '0);
        @(negedge clk);
        psum_valid = 1'b0;
        rst_n      = 1'b1;
        #1;
        chk_i("abort_idle", int'(busy), 0);
        chk_i("abort_no_done", int'(done), 0);

        rv = '{4, 3, 1, 2, 1'b1, 1'b0, -1};
        run_job(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
